muldiv_seq: RTL and testbench

//  Iterative signed multiplier/divider for the calculator datapath. Drives muldiv_res and

---
 rtl/calc_pkg.sv | 9 +
 rtl/muldiv_sign_fix.sv | 20 ++
 rtl/muldiv_seq.sv | 118 +++++++++++
 tb/tb_muldiv_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, datapath width and muldiv FSM states for the calculator.
package calc_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam int CALC_W = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} muldiv_state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: applies result sign to an unsigned magnitude, range-checks, zeroes on error.
module muldiv_sign_fix
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic [2*W-1:0] mag,
  input  logic           neg,
  input  logic           div,
  input  logic           div0,
  output logic [W-1:0]   res,
  output logic           err
);
  localparam logic [2*W-1:0] MAX_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] MAX_NEG = MAX_POS + 1'b1;
  always_comb begin
    err = (div & div0) | (mag > (neg ? MAX_NEG : MAX_POS));
    res = err ? '0 : (neg ? -mag[W-1:0] : mag[W-1:0]);
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed shift-add multiplier / restoring divider, fixed 9-cycle latency.
module muldiv_seq
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op_sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] muldiv_res,
  output logic         muldiv_err
);
  localparam int CW = $clog2(W);
  muldiv_state_t state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           div_q, div_d, neg_q, neg_d;
  logic [W-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_q, err_d, done_q, done_d;
  logic [CW-1:0]  idx;
  logic [W:0]     rem_sh;
  logic           ge;
  logic [W-1:0]   fix_res;
  logic           fix_err;

  muldiv_sign_fix #(.W(W)) u_fix (
    .mag  (acc_q),
    .neg  (neg_q),
    .div  (div_q),
    .div0 (mb_q == '0),
    .res  (fix_res),
    .err  (fix_err)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    neg_d   = neg_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    err_d   = err_q;
    done_d  = 1'b0;
    idx     = CW'(W-1) - count_q;
    rem_sh  = {rem_q, ma_q[idx]};
    ge      = rem_sh >= {1'b0, mb_q};
    unique case (state_q)
      ST_IDLE: if (start && op_sel[1]) begin
        div_d   = op_sel[0];
        neg_d   = a[W-1] ^ b[W-1];
        ma_d    = a[W-1] ? -a : a;
        mb_d    = b[W-1] ? -b : b;
        count_d = '0;
        acc_d   = '0;
        rem_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Divide reuses the accumulator as the quotient shift register.
        acc_d   = div_q ? {acc_q[2*W-2:0], ge}
                        : acc_q + (mb_q[count_q] ? ({{W{1'b0}}, ma_q} << count_q) : '0);
        rem_d   = div_q ? W'(ge ? rem_sh - {1'b0, mb_q} : rem_sh) : rem_q;
        count_d = count_q + 1'b1;
        state_d = (count_q == CW'(W-1)) ? ST_FIN : ST_RUN;
      end
      ST_FIN: begin
        res_d   = fix_res;
        err_d   = fix_err;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy       = state_q != ST_IDLE;
  assign done       = done_q;
  assign muldiv_res = res_q;
  assign muldiv_err = err_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random and directed stimulus checked every cycle against an arithmetic model.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] op_sel = 2'b00;
  logic signed [7:0] a = '0, b = '0;
  logic busy, done, muldiv_err;
  logic [7:0] muldiv_res;
  int checks = 0, errors = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .a(a), .b(b),
    .busy(busy), .done(done), .muldiv_res(muldiv_res), .muldiv_err(muldiv_err)
  );

  always #5 clk = ~clk;

  function automatic logic model_err(input logic div, input logic signed [7:0] x, input logic signed [7:0] y);
    int p;
    if (div) return (y == 0) || ((int'(x) / int'(y)) == 128);
    p = int'(x) * int'(y);
    return (p < -128) || (p > 127);
  endfunction

  function automatic int model_res(input logic div, input logic signed [7:0] x, input logic signed [7:0] y);
    if (model_err(div, x, y)) return 0;
    return div ? int'(x) / int'(y) : int'(x) * int'(y);
  endfunction

  int cnt = 0;
  logic exp_done = 1'b0, exp_err = 1'b0, pend_err = 1'b0;
  int exp_res = 0, pend_res = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0; exp_done <= 1'b0; exp_res <= 0; exp_err <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          exp_done <= 1'b1; exp_res <= pend_res; exp_err <= pend_err;
        end
      end else if (start && op_sel[1]) begin
        pend_res <= model_res(op_sel[0], a, b);
        pend_err <= model_err(op_sel[0], a, b);
        cnt <= 9;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("busy", int'(busy), int'(cnt != 0));
    chk("done", int'(done), int'(exp_done));
    chk("res", int'($signed(muldiv_res)), exp_res);
    chk("err", int'(muldiv_err), int'(exp_err));
  end

  task automatic run_op(input logic [1:0] op, input logic signed [7:0] x, input logic signed [7:0] y,
                        input int er, input logic ee);
    int n;
    @(negedge clk);
    start = 1'b1; op_sel = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 9);
    chk("op_res", int'($signed(muldiv_res)), er);
    chk("op_err", int'(muldiv_err), int'(ee));
  endtask

  function automatic logic signed [7:0] pick();
    case ($urandom_range(0, 5))
      0: return -8'sd128;
      1: return -8'sd1;
      2: return 8'sd0;
      3: return 8'sd1;
      4: return 8'sd127;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n, d1, d2;
    chk("pin_mul", model_res(1'b0, 8'sd7, -8'sd6), -42);
    chk("pin_div", model_res(1'b1, 8'sd100, -8'sd7), -14);
    chk("pin_ovf", int'(model_err(1'b1, -8'sd128, -8'sd1)), 1);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_res", int'(muldiv_res), 0);
    chk("rst_err", int'(muldiv_err), 0);
    #20 rst = 1'b0;
    run_op(2'b10, 8'sd7, -8'sd6, -42, 1'b0);
    run_op(2'b10, -8'sd16, 8'sd8, -128, 1'b0);
    run_op(2'b10, 8'sd16, 8'sd8, 0, 1'b1);
    run_op(2'b10, -8'sd128, -8'sd1, 0, 1'b1);
    run_op(2'b10, -8'sd128, 8'sd1, -128, 1'b0);
    run_op(2'b11, -8'sd7, 8'sd2, -3, 1'b0);
    run_op(2'b11, 8'sd100, -8'sd7, -14, 1'b0);
    run_op(2'b11, -8'sd128, 8'sd1, -128, 1'b0);
    run_op(2'b11, -8'sd128, -8'sd1, 0, 1'b1);
    run_op(2'b11, 8'sd5, 8'sd0, 0, 1'b1);
    // second start while busy is dropped
    @(negedge clk);
    start = 1'b1; op_sel = 2'b10; a = 8'sd5; b = 8'sd5;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op_sel = 2'b11; a = 8'sd9; b = 8'sd3;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_ign_res", int'($signed(muldiv_res)), 25);
    start = 1'b1; op_sel = 2'b01;
    repeat (4) @(negedge clk);
    chk("nonmd_busy", int'(busy), 0);
    start = 1'b0;
    // reset during RUN
    @(negedge clk);
    start = 1'b1; op_sel = 2'b10; a = 8'sd3; b = 8'sd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_res", int'(muldiv_res), 0);
    chk("mid_rst_err", int'(muldiv_err), 0);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(2'b10, -8'sd11, 8'sd11, -121, 1'b0);
    // start held high: back-to-back ops
    @(negedge clk);
    start = 1'b1; op_sel = 2'b10; a = 8'sd3; b = 8'sd4;
    @(posedge clk); #1;
    d1 = -1; d2 = -1;
    for (n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (done && d1 < 0) d1 = n;
      else if (done && d2 < 0) d2 = n;
    end
    chk("b2b_first", d1, 9);
    chk("b2b_second", d2, 19);
    start = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      op_sel = 2'($urandom);
      a = pick();
      b = pick();
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
